// File: rtl/instr_decoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_decoder_pipe                                         |
// | Description : Two-stage registered instruction decoder. Stage 1 latches  |
// |               the instruction word under valid/ready, stage 2 registers  |
// |               the decoded datapath controls. Post-reset hold sequence,   |
// |               datapath stall and a one-cycle squash after jumps.         |
// |               Optional: define INSTR_COUNT_EN to add the 16-bit          |
// |               instr_count output (retired-instruction counter).          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module instr_decoder_pipe #(
  parameter int IR_W         = 8,
  parameter int RESET_CYCLES = 2,
  parameter int FLUSH_ON_JMP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IR_W-1:0] instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            stall,
  output logic            dec_valid,
  output logic            jmp,
  output logic            jmp_nz,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic [3:0]      source_sel,
  output logic [IR_W-5:0] imm,
  output logic [8:0]      reg_en
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]     instr_count
`endif
);

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;

  localparam logic [3:0] c_src_mem  = 4'd8;
  localparam logic [3:0] c_src_pins = 4'd9;
  localparam logic [3:0] c_src_idle = 4'd10;

  localparam int                c_cnt_w     = $clog2(RESET_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RESET_CYCLES - 1);

  // Destination code to write-enable bit: code 4 is the output register (bit 8)
  function automatic logic [8:0] dst_onehot(input logic [2:0] dst);
    dst_onehot = (dst == 3'd4) ? 9'h100 : (9'h001 << dst);
  endfunction

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_hold_cnt;
  logic               w_hold_done;
  logic               w_instr_ready;
  logic               w_accept;
  logic               w_jmp_issue;

  logic [IR_W-1:0]    r_ir;
  logic               r_ir_valid;

  logic               r_dec_valid;
  logic               r_jmp;
  logic               r_jmp_nz;
  logic               r_i_sel;
  logic               r_x_sel;
  logic               r_y_sel;
  logic [3:0]         r_source_sel;
  logic [IR_W-5:0]    r_imm;
  logic [8:0]         r_reg_en;

  logic [3:0]         w_op;
  logic [2:0]         w_ld_dst;
  logic [2:0]         w_mv_dst;
  logic [2:0]         w_mv_src;
  logic               w_jmp;
  logic               w_jmp_nz;
  logic               w_i_sel;
  logic               w_x_sel;
  logic               w_y_sel;
  logic [3:0]         w_src;
  logic [8:0]         w_reg_en;

  assign w_op     = r_ir[IR_W-1 -: 4];
  assign w_ld_dst = r_ir[IR_W-2 -: 3];
  assign w_mv_dst = r_ir[IR_W-3 -: 3];
  assign w_mv_src = r_ir[IR_W-6 -: 3];

  assign w_hold_done = (r_state == S_HOLD) && (r_hold_cnt == c_hold_last);
  assign w_accept    = instr_valid && w_instr_ready;
  // A jump being registered into stage 2 this edge arms the squash of its successor
  assign w_jmp_issue = (FLUSH_ON_JMP != 0) && !stall && r_ir_valid && (w_jmp || w_jmp_nz);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_HOLD;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOLD:   if (w_hold_done) w_state_nxt = S_RUN;
      S_RUN:    if (w_jmp_issue) w_state_nxt = S_SQUASH;
      S_SQUASH: if (!stall)      w_state_nxt = S_RUN;
      default:                   w_state_nxt = S_HOLD;
    endcase
  end

  // FSM outputs: no fetch while holding after reset or while the datapath stalls
  always_comb begin
    w_instr_ready = (r_state != S_HOLD) && !stall;
  end

  // Post-reset hold counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_hold_cnt <= '0;
    else if (r_state == S_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  // Stage 1: instruction register; a stall freezes both the word and its valid flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_accept) begin
      r_ir       <= instr_in;
      r_ir_valid <= 1'b1;
    end else if (!stall) begin
      r_ir_valid <= 1'b0;
    end
  end

  // Combinational decode of the instruction register
  always_comb begin
    w_jmp    = 1'b0;
    w_jmp_nz = 1'b0;
    w_i_sel  = 1'b1;
    w_x_sel  = 1'b0;
    w_y_sel  = 1'b0;
    w_src    = c_src_idle;
    w_reg_en = '0;
    if (!w_op[3]) begin
      // load immediate from program memory
      w_src    = c_src_mem;
      w_reg_en = dst_onehot(w_ld_dst);
      if (w_ld_dst[2:1] == 2'b11) begin
        w_reg_en[6] = 1'b1;
        w_i_sel     = 1'b0;
      end
    end else if (w_op[3:2] == 2'b10) begin
      // register move; src==dst encodes output-register or pin reads
      if (w_mv_src == w_mv_dst) w_src = (w_mv_dst == 3'd4) ? 4'd4 : c_src_pins;
      else                      w_src = {1'b0, w_mv_src};
      w_reg_en = dst_onehot(w_mv_dst);
      if (w_mv_dst[2:1] == 2'b11 || w_mv_src == 3'd7) w_reg_en[6] = 1'b1;
      if (w_mv_dst == 3'd6) w_i_sel = 1'b0;
    end else if (w_op[3:1] == 3'b110) begin
      w_reg_en[4] = 1'b1;
      w_x_sel     = w_op[0];
      w_y_sel     = r_ir[IR_W-5];
    end else if (!w_op[0]) begin
      w_jmp = 1'b1;
    end else begin
      w_jmp_nz = 1'b1;
    end
  end

  // Stage 2: decoded control registers (bubble on empty IR or squash, hold on stall)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dec_valid  <= 1'b0;
      r_jmp        <= 1'b0;
      r_jmp_nz     <= 1'b0;
      r_i_sel      <= 1'b0;
      r_x_sel      <= 1'b0;
      r_y_sel      <= 1'b0;
      r_source_sel <= c_src_idle;
      r_imm        <= '0;
      r_reg_en     <= 9'h1FF;
    end else if (r_state == S_HOLD) begin
      if (w_hold_done) begin
        r_dec_valid  <= 1'b0;
        r_jmp        <= 1'b0;
        r_jmp_nz     <= 1'b0;
        r_source_sel <= c_src_idle;
        r_reg_en     <= '0;
      end
    end else if (!stall) begin
      if (r_ir_valid && r_state != S_SQUASH) begin
        r_dec_valid  <= 1'b1;
        r_jmp        <= w_jmp;
        r_jmp_nz     <= w_jmp_nz;
        r_i_sel      <= w_i_sel;
        r_x_sel      <= w_x_sel;
        r_y_sel      <= w_y_sel;
        r_source_sel <= w_src;
        r_imm        <= r_ir[IR_W-5:0];
        r_reg_en     <= w_reg_en;
      end else begin
        r_dec_valid  <= 1'b0;
        r_jmp        <= 1'b0;
        r_jmp_nz     <= 1'b0;
        r_source_sel <= c_src_idle;
        r_reg_en     <= '0;
      end
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_instr_count <= '0;
    else if (r_dec_valid && !stall) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`endif

  assign instr_ready = w_instr_ready;
  assign dec_valid   = r_dec_valid;
  assign jmp         = r_jmp;
  assign jmp_nz      = r_jmp_nz;
  assign i_sel       = r_i_sel;
  assign x_sel       = r_x_sel;
  assign y_sel       = r_y_sel;
  assign source_sel  = r_source_sel;
  assign imm         = r_imm;
  // Write enables are suppressed while the datapath is stalled; the register keeps them
  assign reg_en      = r_reg_en & {9{~stall}};

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_decoder_pipe                                      |
// | Description : Self-checking bench for instr_decoder_pipe: transaction    |
// |               model compared every cycle plus directed literal checks.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_instr_decoder_pipe;

  localparam int RESET_CYCLES = 2;
  localparam int FLUSH        = 1;

  typedef struct packed {
    logic       dec_valid;
    logic       jmp;
    logic       jmp_nz;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic [3:0] src;
    logic [3:0] imm;
    logic [8:0] reg_en;
  } dec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       stall;
  logic       dec_valid, jmp, jmp_nz, i_sel, x_sel, y_sel;
  logic [3:0] source_sel;
  logic [3:0] imm;
  logic [8:0] reg_en;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_decoder_pipe #(
    .IR_W        (8),
    .RESET_CYCLES(RESET_CYCLES),
    .FLUSH_ON_JMP(FLUSH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .stall      (stall),
    .dec_valid  (dec_valid),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .source_sel (source_sel),
    .imm        (imm),
    .reg_en     (reg_en)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  dec_t        m_out;
  int          m_hold_left;
  logic [7:0]  m_pending[$];
  bit          m_drop;
  logic [15:0] m_count;

  // Decode rules expressed on the numeric value of the instruction byte
  function automatic dec_t model_decode(input logic [7:0] w);
    dec_t d;
    int   v, top, dst, src;
    v   = int'(w);
    top = v / 16;
    d.dec_valid = 1'b1;
    d.jmp       = 1'b0;
    d.jmp_nz    = 1'b0;
    d.i_sel     = 1'b1;
    d.x_sel     = 1'b0;
    d.y_sel     = 1'b0;
    d.src       = 4'd10;
    d.imm       = 4'(v % 16);
    d.reg_en    = 9'd0;
    if (top < 8) begin
      dst = top;
      d.src = 4'd8;
      d.reg_en[(dst == 4) ? 8 : dst] = 1'b1;
      if (dst >= 6) begin
        d.reg_en[6] = 1'b1;
        d.i_sel     = 1'b0;
      end
    end else if (top < 12) begin
      dst = (v / 8) % 8;
      src = v % 8;
      if (src != dst)    d.src = 4'(src);
      else if (dst == 4) d.src = 4'd4;
      else               d.src = 4'd9;
      d.reg_en[(dst == 4) ? 8 : dst] = 1'b1;
      if (dst >= 6 || src == 7) d.reg_en[6] = 1'b1;
      if (dst == 6) d.i_sel = 1'b0;
    end else if (top < 14) begin
      d.reg_en = 9'h010;
      d.x_sel  = 1'(top % 2);
      d.y_sel  = 1'((v / 8) % 2);
    end else if (top == 14) begin
      d.jmp = 1'b1;
    end else begin
      d.jmp_nz = 1'b1;
    end
    return d;
  endfunction

  task automatic model_bubble();
    m_out.dec_valid = 1'b0;
    m_out.jmp       = 1'b0;
    m_out.jmp_nz    = 1'b0;
    m_out.src       = 4'd10;
    m_out.reg_en    = 9'd0;
  endtask

  task automatic model_reset();
    m_hold_left = RESET_CYCLES;
    m_pending.delete();
    m_drop  = 1'b0;
    m_count = 16'd0;
    m_out.dec_valid = 1'b0;
    m_out.jmp       = 1'b0;
    m_out.jmp_nz    = 1'b0;
    m_out.i_sel     = 1'b0;
    m_out.x_sel     = 1'b0;
    m_out.y_sel     = 1'b0;
    m_out.src       = 4'd10;
    m_out.imm       = 4'd0;
    m_out.reg_en    = 9'h1FF;
  endtask

  task automatic model_clock();
    bit         acc;
    logic [7:0] w;
    acc = instr_valid && (m_hold_left == 0) && !stall;
    if (m_out.dec_valid && !stall) m_count = m_count + 16'd1;
    if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) model_bubble();
    end else if (!stall) begin
      if (m_pending.size() > 0) begin
        w = m_pending.pop_front();
        if (m_drop) model_bubble();
        else        m_out = model_decode(w);
      end else begin
        model_bubble();
      end
      m_drop = (FLUSH != 0) && (m_out.jmp || m_out.jmp_nz);
    end
    if (acc) m_pending.push_back(instr_in);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_clock();
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmp_dec_valid", 32'(dec_valid), 32'(m_out.dec_valid));
    chk("cmp_jmp", 32'(jmp), 32'(m_out.jmp));
    chk("cmp_jmp_nz", 32'(jmp_nz), 32'(m_out.jmp_nz));
    chk("cmp_source_sel", 32'(source_sel), 32'(m_out.src));
    chk("cmp_imm", 32'(imm), 32'(m_out.imm));
    chk("cmp_reg_en", 32'(reg_en), 32'(stall ? 9'd0 : m_out.reg_en));
    chk("cmp_ready", 32'(instr_ready), 32'(reset_n && m_hold_left == 0 && !stall));
    if (m_out.dec_valid) begin
      chk("cmp_i_sel", 32'(i_sel), 32'(m_out.i_sel));
      chk("cmp_x_sel", 32'(x_sel), 32'(m_out.x_sel));
      chk("cmp_y_sel", 32'(y_sel), 32'(m_out.y_sel));
    end
`ifdef INSTR_COUNT_EN
    chk("cmp_count", 32'(instr_count), 32'(m_count));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] w, input logic s);
    instr_valid = v;
    instr_in    = w;
    stall       = s;
  endtask

  task automatic release_reset();
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (RESET_CYCLES) step();
  endtask

  logic [7:0] tbl [16] = '{8'h65, 8'h7A, 8'hB1, 8'hC8, 8'hF7, 8'h3C, 8'h8F, 8'h92,
                           8'hE0, 8'hD8, 8'h4E, 8'hA3, 8'hBE, 8'hB6, 8'h1F, 8'hDF};

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();

    // Reset and post-reset hold
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t1_reg_en", 32'(reg_en), 32'h1FF);
    chk("t1_src", 32'(source_sel), 32'd10);
    chk("t1_ready", 32'(instr_ready), 32'd0);
    chk("t1_dec_valid", 32'(dec_valid), 32'd0);
    step();
    chk("t1_hold_reg_en", 32'(reg_en), 32'h1FF);
    chk("t1_hold_ready", 32'(instr_ready), 32'd0);
    step();
    chk("t1_run_ready", 32'(instr_ready), 32'd1);

    // Back-to-back stream
    drive(1'b1, 8'h05, 1'b0); step();
    drive(1'b1, 8'h9A, 1'b0); step();
    chk("t2_05_reg_en", 32'(reg_en), 32'h001);
    chk("t2_05_src", 32'(source_sel), 32'd8);
    chk("t2_05_imm", 32'(imm), 32'd5);
    drive(1'b1, 8'hD0, 1'b0); step();
    chk("t2_9a_reg_en", 32'(reg_en), 32'h008);
    chk("t2_9a_src", 32'(source_sel), 32'd2);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("t2_d0_reg_en", 32'(reg_en), 32'h010);
    chk("t2_d0_x_sel", 32'(x_sel), 32'd1);
    step();
    chk("t2_bubble_valid", 32'(dec_valid), 32'd0);
    chk("t2_bubble_src", 32'(source_sel), 32'd10);

    // Jump squashes its successor only
    drive(1'b1, 8'hE3, 1'b0); step();
    drive(1'b1, 8'h10, 1'b0); step();
    chk("t3_jmp", 32'(jmp), 32'd1);
    chk("t3_jmp_imm", 32'(imm), 32'd3);
    drive(1'b1, 8'h21, 1'b0); step();
    chk("t3_squash_valid", 32'(dec_valid), 32'd0);
    chk("t3_squash_reg_en", 32'(reg_en), 32'h000);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("t3_next_valid", 32'(dec_valid), 32'd1);
    chk("t3_next_reg_en", 32'(reg_en), 32'h004);
    step();

    // Stall while 8'hBF is at the output, with 8'h05 waiting in IR
    drive(1'b1, 8'hBF, 1'b0); step();
    drive(1'b1, 8'h05, 1'b0); step();
    chk("t4_pre_reg_en", 32'(reg_en), 32'h0C0);
    drive(1'b1, 8'h33, 1'b1); #1;
    chk("t4_stall_reg_en", 32'(reg_en), 32'h000);
    chk("t4_stall_ready", 32'(instr_ready), 32'd0);
    step();
    chk("t4_stall_src", 32'(source_sel), 32'd9);
    step();
    drive(1'b0, 8'h00, 1'b0); #1;
    chk("t4_release_reg_en", 32'(reg_en), 32'h0C0);
    chk("t4_release_src", 32'(source_sel), 32'd9);
    step();
    chk("t4_ir_held_reg_en", 32'(reg_en), 32'h001);
    chk("t4_ir_held_imm", 32'(imm), 32'd5);
    step();
    chk("t4_no_accept", 32'(dec_valid), 32'd0);

    // Moves involving the output register and dm
    drive(1'b1, 8'hA4, 1'b0); step();
    drive(1'b1, 8'h87, 1'b0); step();
    chk("t5_a4_reg_en", 32'(reg_en), 32'h100);
    chk("t5_a4_src", 32'(source_sel), 32'd4);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("t5_87_reg_en", 32'(reg_en), 32'h041);
    chk("t5_87_src", 32'(source_sel), 32'd7);
    step();

    // Stall during the squash cycle does not lose the squash
    drive(1'b1, 8'hF7, 1'b0); step();
    drive(1'b1, 8'h11, 1'b0); step();
    chk("t7_jmp_nz", 32'(jmp_nz), 32'd1);
    drive(1'b0, 8'h00, 1'b1); step(); step();
    chk("t7_held_jmp_nz", 32'(jmp_nz), 32'd1);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("t7_squash_valid", 32'(dec_valid), 32'd0);
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0); step();
    chk("t7_after_reg_en", 32'(reg_en), 32'h004);
    chk("t7_after_imm", 32'(imm), 32'd2);
    step();

    // Asynchronous reset in the middle of an instruction
    drive(1'b1, 8'h7A, 1'b0); step(); step();
    chk("t8_pre_reg_en", 32'(reg_en), 32'h0C0);
    #2 reset_n = 1'b0;
    #1;
    chk("t8_rst_reg_en", 32'(reg_en), 32'h1FF);
    chk("t8_rst_valid", 32'(dec_valid), 32'd0);
    chk("t8_rst_ready", 32'(instr_ready), 32'd0);
    release_reset();

`ifdef INSTR_COUNT_EN
    drive(1'b1, 8'h05, 1'b0);
    repeat (65537) step();
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) step();
    chk("t6_count_wrap", 32'(instr_count), 32'd1);
    drive(1'b1, 8'h05, 1'b0);
    repeat (10) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(instr_count), 32'd0);
    chk("t6_rst_reg_en", 32'(reg_en), 32'h1FF);
    release_reset();
`endif

    // Mixed stream with gaps and stalls, checked by the model
    for (int i = 0; i < 96; i++) begin
      drive((i % 5) != 3, tbl[i % 16], (i % 7) == 4);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
